// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract unit. The carry chain is split into STAGES
// chunks of CW bits, one chunk per register stage, with a valid/ready handshake.
module addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    localparam int CW = WIDTH / STAGES;

    logic             stall;
    logic [WIDTH-1:0] bx_in;
    logic             v_q;
    logic             z_q;

    function automatic logic ovf_flag(input logic a_msb, input logic bx_msb, input logic d_msb);
        return (a_msb == bx_msb) && (d_msb != a_msb);
    endfunction

    assign bx_in = mode ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operand bits still waiting for their chunk of the carry chain.
        localparam int R = WIDTH - (k + 1) * CW;

        logic [CW-1:0]         a_c;
        logic [CW-1:0]         b_c;
        logic                  c_in;
        logic                  v_in;
        logic [CW:0]           sum;
        logic [(k+1)*CW-1:0]   d_nxt;
        logic [(k+1)*CW-1:0]   d_p;
        logic                  cy_p;
        logic                  vld_p;

        if (k == 0) begin : g_src
            assign a_c   = A[CW-1:0];
            assign b_c   = bx_in[CW-1:0];
            assign c_in  = cin;
            assign v_in  = in_valid;
            assign d_nxt = sum[CW-1:0];
        end else begin : g_src
            assign a_c   = g_st[k-1].g_fwd.a_p[CW-1:0];
            assign b_c   = g_st[k-1].g_fwd.bx_p[CW-1:0];
            assign c_in  = g_st[k-1].cy_p;
            assign v_in  = g_st[k-1].vld_p;
            assign d_nxt = {sum[CW-1:0], g_st[k-1].d_p};
        end

        assign sum = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, c_in};

        if (R > 0) begin : g_fwd
            logic [R-1:0] a_p;
            logic [R-1:0] bx_p;

            if (k == 0) begin : g_ld
                always_ff @(posedge clk) begin
                    if (!stall) begin
                        a_p  <= A[WIDTH-1:CW];
                        bx_p <= bx_in[WIDTH-1:CW];
                    end
                end
            end else begin : g_ld
                always_ff @(posedge clk) begin
                    if (!stall) begin
                        a_p  <= g_st[k-1].g_fwd.a_p[R+CW-1:CW];
                        bx_p <= g_st[k-1].g_fwd.bx_p[R+CW-1:CW];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p <= 1'b0;
            end else if (!stall) begin
                vld_p <= v_in;
            end
        end

        // Output stage: result and flags only change when a real beat lands,
        // so D keeps the last delivered result across bubbles.
        if (k == STAGES - 1) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    d_p  <= '0;
                    cy_p <= 1'b0;
                    v_q  <= 1'b0;
                    z_q  <= 1'b0;
                end else if (!stall && v_in) begin
                    d_p  <= d_nxt;
                    cy_p <= sum[CW];
                    v_q  <= ovf_flag(a_c[CW-1], b_c[CW-1], sum[CW-1]);
                    z_q  <= ~|d_nxt;
                end
            end
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (!stall) begin
                    d_p  <= d_nxt;
                    cy_p <= sum[CW];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_p;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign D         = g_st[STAGES-1].d_p;
    assign Cout      = g_st[STAGES-1].cy_p;
    assign V         = v_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed vectors on an 8/2 instance plus random
// streams on 16/4 and 4/1 instances, checked through per-instance scoreboards.
module tb_addsub_pipe;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        v;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // 8-bit, 2-stage instance
    logic       iv0, ir0, ov0, or0, m0, c0, co0, v0, z0;
    logic [7:0] a0, b0, d0;
    // 16-bit, 4-stage instance
    logic        iv1, ir1, ov1, or1, m1, c1, co1, v1, z1;
    logic [15:0] a1, b1, d1;
    // 4-bit, 1-stage instance
    logic       iv2, ir2, ov2, or2, m2, c2, co2, v2, z2;
    logic [3:0] a2, b2, d2;

    logic last_co0;

    addsub_pipe #(.WIDTH(8), .STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .mode(m0), .cin(c0), .out_valid(ov0), .out_ready(or0), .D(d0), .Cout(co0),
        .V(v0), .Z(z0)
    );

    addsub_pipe #(.WIDTH(16), .STAGES(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .mode(m1), .cin(c1), .out_valid(ov1), .out_ready(or1), .D(d1), .Cout(co1),
        .V(v1), .Z(z1)
    );

    addsub_pipe #(.WIDTH(4), .STAGES(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .mode(m2), .cin(c2), .out_valid(ov2), .out_ready(or2), .D(d2), .Cout(co2),
        .V(v2), .Z(z2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Flat reference: whole-word sum, no chunking.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic m, input logic c, input int acc, input bit lat);
        exp_t        e;
        logic [16:0] mask;
        logic [16:0] bx;
        logic [16:0] s;
        mask  = 17'((17'd1 << w) - 17'd1);
        bx    = (m ? ~{1'b0, b} : {1'b0, b}) & mask;
        s     = ({1'b0, a} & mask) + bx + {16'b0, c};
        e.d   = s[15:0] & mask[15:0];
        e.c   = s[w];
        e.v   = (a[w-1] == bx[w-1]) && (e.d[w-1] != a[w-1]);
        e.z   = (e.d == 16'd0);
        e.acc = acc;
        e.lat = lat;
        return e;
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic drain(input int which);
        int n = 0;
        while (qsize(which) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (qsize(which) != 0) begin
            checks++;
            failures++;
            $display("FAIL drain%0d pending=%0d required=0", which, qsize(which));
        end
    endtask

    task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic m, input logic c,
                         input logic [7:0] ed, input logic ec, input logic ev, input logic ez,
                         input bit lat, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        a0 = a; b0 = b; m0 = m; c0 = c; iv0 = 1'b1;
        #1;
        while (!ir0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ir0) begin
            checks++;
            failures++;
            $display("FAIL accept0 in_ready actual=0 required=1");
        end else if (push) begin
            e.d = {8'b0, ed}; e.c = ec; e.v = ev; e.z = ez;
            e.acc = cyc + 1; e.lat = lat;
            q0.push_back(e);
        end
    endtask

    task automatic idle0();
        @(negedge clk);
        iv0 = 1'b0;
    endtask

    // Monitors: sampled 2 time units after the falling edge.
    exp_t        e0, e1, e2;
    logic        stl0 = 1'b0, stl1 = 1'b0, stl2 = 1'b0;
    logic [31:0] hold0, hold1, hold2;
    int          first0, first1, first2;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            stl0 = 1'b0;
        end else begin
            if (stl0) chk("hold0", 32'({ov0, d0, co0, v0, z0}), hold0);
            if (ov0 && !stl0) first0 = cyc;
            if (ov0 && !or0) chk("in_ready0_stall", 32'(ir0), 32'(0));
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out0_unexpected d=%0h required=no beat", d0);
                end else begin
                    e0 = q0.pop_front();
                    chk("d0", 32'(d0), 32'(e0.d));
                    chk("cout0", 32'(co0), 32'(e0.c));
                    chk("v0", 32'(v0), 32'(e0.v));
                    chk("z0", 32'(z0), 32'(e0.z));
                    last_co0 = co0;
                    if (e0.lat) chk("lat0", 32'(first0), 32'(e0.acc + 1));
                end
            end
            stl0  = ov0 && !or0;
            hold0 = 32'({ov0, d0, co0, v0, z0});
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            stl1 = 1'b0;
        end else begin
            if (stl1) chk("hold1", 32'({ov1, d1, co1, v1, z1}), hold1);
            if (ov1 && !stl1) first1 = cyc;
            if (ov1 && !or1) chk("in_ready1_stall", 32'(ir1), 32'(0));
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out1_unexpected d=%0h required=no beat", d1);
                end else begin
                    e1 = q1.pop_front();
                    chk("res1", 32'({d1, co1, v1, z1}), 32'({e1.d, e1.c, e1.v, e1.z}));
                    if (e1.lat) chk("lat1", 32'(first1), 32'(e1.acc + 3));
                end
            end
            stl1  = ov1 && !or1;
            hold1 = 32'({ov1, d1, co1, v1, z1});
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            stl2 = 1'b0;
        end else begin
            if (stl2) chk("hold2", 32'({ov2, d2, co2, v2, z2}), hold2);
            if (ov2 && !stl2) first2 = cyc;
            if (ov2 && !or2) chk("in_ready2_stall", 32'(ir2), 32'(0));
            if (ov2 && or2) begin
                if (q2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out2_unexpected d=%0h required=no beat", d2);
                end else begin
                    e2 = q2.pop_front();
                    chk("res2", 32'({d2, co2, v2, z2}), 32'({e2.d[3:0], e2.c, e2.v, e2.z}));
                    if (e2.lat) chk("lat2", 32'(first2), 32'(e2.acc));
                end
            end
            stl2  = ov2 && !or2;
            hold2 = 32'({ov2, d2, co2, v2, z2});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        iv0 = 0; or0 = 1; a0 = '0; b0 = '0; m0 = 0; c0 = 0;
        iv1 = 0; or1 = 1; a1 = '0; b1 = '0; m1 = 0; c1 = 0;
        iv2 = 0; or2 = 1; a2 = '0; b2 = '0; m2 = 0; c2 = 0;
        last_co0 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_out_valid", 32'(ov0), 32'(0));
        chk("rst_d", 32'(d0), 32'(0));
        chk("rst_flags", 32'({co0, v0, z0}), 32'(0));
        chk("rst_in_ready", 32'(ir0), 32'(1));

        // Basic add/subtract vectors, no stall, latency checked.
        send0(8'hF0, 8'h20, 0, 0, 8'h10, 1, 0, 0, 1, 1);
        send0(8'h80, 8'h01, 1, 1, 8'h7F, 1, 1, 0, 1, 1);
        send0(8'h05, 8'h05, 1, 1, 8'h00, 1, 0, 1, 1, 1);
        send0(8'h03, 8'h05, 1, 1, 8'hFE, 0, 0, 0, 1, 1);
        send0(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0, 1, 1);
        send0(8'hFF, 8'h00, 0, 1, 8'h00, 1, 0, 1, 1, 1);
        idle0();
        drain(0);

        // Beat in flight when reset hits: must vanish.
        send0(8'h11, 8'h22, 0, 0, 8'h33, 0, 0, 0, 0, 0);
        @(negedge clk);
        iv0 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("rstmid_out_valid", 32'(ov0), 32'(0));
            chk("rstmid_d", 32'(d0), 32'(0));
        end

        // Two-word chain 0x12FF + 0x0001.
        send0(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1, 1, 1);
        idle0();
        drain(0);
        send0(8'h12, 8'h00, 0, last_co0, 8'h13, 0, 0, 0, 1, 1);
        idle0();
        drain(0);

        // Six back-to-back beats with a 3-cycle consumer stall.
        fork
            begin
                send0(8'h01, 8'h02, 0, 0, 8'h03, 0, 0, 0, 0, 1);
                send0(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0, 0, 1);
                send0(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1, 0, 1);
                send0(8'h10, 8'h20, 1, 1, 8'hF0, 0, 0, 0, 0, 1);
                send0(8'hAA, 8'h55, 0, 0, 8'hFF, 0, 0, 0, 0, 1);
                send0(8'hC0, 8'hC0, 0, 0, 8'h80, 1, 0, 0, 0, 1);
                idle0();
            end
            begin
                repeat (4) @(negedge clk);
                or0 = 1'b0;
                repeat (3) @(negedge clk);
                or0 = 1'b1;
            end
        join
        drain(0);

        // Random sweeps: first phase with ready held high checks latency.
        fork
            begin : sweep1
                exp_t e;
                int   n;
                for (int ph = 0; ph < 2; ph++) begin
                    for (int i = 0; i < (ph == 0 ? 200 : 800); i++) begin
                        @(negedge clk);
                        or1 = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                        if ($urandom_range(0, 3) == 0) begin
                            iv1 = 1'b0;
                            @(negedge clk);
                            or1 = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                        end
                        a1 = 16'($urandom); b1 = 16'($urandom);
                        m1 = 1'($urandom); c1 = 1'($urandom); iv1 = 1'b1;
                        #1;
                        n = 0;
                        while (!ir1 && n < 100) begin
                            @(negedge clk);
                            or1 = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                            #1;
                            n++;
                        end
                        if (!ir1) begin
                            checks++;
                            failures++;
                            $display("FAIL accept1 in_ready actual=0 required=1");
                        end else begin
                            e = model(16, a1, b1, m1, c1, cyc + 1, ph == 0);
                            q1.push_back(e);
                        end
                    end
                    @(negedge clk);
                    iv1 = 1'b0;
                    or1 = 1'b1;
                    drain(1);
                end
            end
            begin : sweep2
                exp_t e;
                int   n;
                for (int ph = 0; ph < 2; ph++) begin
                    for (int i = 0; i < (ph == 0 ? 200 : 800); i++) begin
                        @(negedge clk);
                        or2 = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                        if ($urandom_range(0, 3) == 0) begin
                            iv2 = 1'b0;
                            @(negedge clk);
                            or2 = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                        end
                        a2 = 4'($urandom); b2 = 4'($urandom);
                        m2 = 1'($urandom); c2 = 1'($urandom); iv2 = 1'b1;
                        #1;
                        n = 0;
                        while (!ir2 && n < 100) begin
                            @(negedge clk);
                            or2 = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                            #1;
                            n++;
                        end
                        if (!ir2) begin
                            checks++;
                            failures++;
                            $display("FAIL accept2 in_ready actual=0 required=1");
                        end else begin
                            e = model(4, {12'b0, a2}, {12'b0, b2}, m2, c2, cyc + 1, ph == 0);
                            q2.push_back(e);
                        end
                    end
                    @(negedge clk);
                    iv2 = 1'b0;
                    or2 = 1'b1;
                    drain(2);
                end
            end
        join

        repeat (5) @(negedge clk);
        chk("q0_empty", 32'(q0.size()), 32'(0));
        chk("q1_empty", 32'(q1.size()), 32'(0));
        chk("q2_empty", 32'(q2.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
